// File: rtl/kasumi_mem_pkg.sv
// Shared types and sizing for the main-clock memory controller.
package kasumi_mem_pkg;

    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 16;
    localparam int LINE_W     = WORD_W * LINE_WORDS;
    localparam int REQ_AW     = 18;
    localparam int FILL_AW    = 8;
    localparam int BEAT_W     = $clog2(LINE_WORDS);
    localparam int MEM_AW     = REQ_AW + BEAT_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL_D,
        ST_FILL_P,
        ST_DONE_D,
        ST_DONE_P
    } mem_state_e;

endpackage

// File: rtl/main_mem_ctrl_line_assembler.sv
// Beat counter plus word register file that packs 16 read beats into one cache line.
module line_assembler
    import kasumi_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              last_beat_o,
    output logic [LINE_W-1:0] line_o
);

    logic [BEAT_W-1:0] beat_q;
    logic [WORD_W-1:0] words_q [LINE_WORDS];

    assign beat_o      = beat_q;
    assign last_beat_o = (beat_q == BEAT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            for (int i = 0; i < LINE_WORDS; i++) words_q[i] <= '0;
        end else if (clear_i) begin
            beat_q <= '0;
            for (int i = 0; i < LINE_WORDS; i++) words_q[i] <= '0;
        end else if (wr_en_i) begin
            words_q[beat_q] <= wdata_i;
            beat_q          <= last_beat_o ? '0 : beat_q + BEAT_W'(1);
        end
    end

    always_comb begin
        line_o = '0;
        for (int i = 0; i < LINE_WORDS; i++) line_o[i*WORD_W +: WORD_W] = words_q[i];
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-clock memory controller: drains write-backs, then services data and prog line fills.
//
// state   | meaning
// IDLE    | arbitrate: write-back > data fill > prog fill
// WB      | one write-back word to memory, pop FIFO on ack
// FILL_D  | 16 word reads for the data cache line
// FILL_P  | 16 word reads for the prog cache line
// DONE_D  | push assembled line to data fill FIFO
// DONE_P  | push assembled line to prog fill FIFO
module main_mem_ctrl
    import kasumi_mem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               is_req_prog,
    input  logic [REQ_AW-1:0]  req_addr_prog,
    input  logic               is_req_data,
    input  logic [REQ_AW-1:0]  req_addr_data,
    input  logic               wb_empty,
    input  logic [31:0]        wb_addr,
    input  logic [WORD_W-1:0]  wb_data,
    output logic               wb_pop,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [WORD_W-1:0]  mem_rdata,
    output logic               fill_prog_valid,
    output logic               fill_data_valid,
    output logic [LINE_W-1:0]  fill_line,
    output logic [FILL_AW-1:0] fill_addr
);

    mem_state_e        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic              fill_prog_valid_q;
    logic              fill_data_valid_q;
    logic [REQ_AW-1:0] line_addr_q;
    logic              served_data_q;
    logic [REQ_AW-1:0] served_addr_data_q;
    logic              served_prog_q;
    logic [REQ_AW-1:0] served_addr_prog_q;

    logic              ack;
    logic              in_fill;
    logic              elig_data;
    logic              elig_prog;
    logic              fill_start;
    logic [REQ_AW-1:0] start_addr;
    logic [BEAT_W-1:0] beat;
    logic              last_beat;
    logic              unused_wb_bits;

    // Only byte-address bits [23:2] form the word address.
    assign unused_wb_bits = ^{wb_addr[31:MEM_AW+2], wb_addr[1:0]};

    assign ack        = mem_ack & mem_req_q;
    assign in_fill    = (state_q == ST_FILL_D) || (state_q == ST_FILL_P);
    assign elig_data  = is_req_data & ~(served_data_q & (req_addr_data == served_addr_data_q));
    assign elig_prog  = is_req_prog & ~(served_prog_q & (req_addr_prog == served_addr_prog_q));
    assign fill_start = (state_q == ST_IDLE) & wb_empty & (elig_data | elig_prog);
    assign start_addr = elig_data ? req_addr_data : req_addr_prog;

    // Pop in the ack cycle so IDLE already sees the next FIFO head.
    assign wb_pop = (state_q == ST_WB) & ack;

    line_assembler u_line (
        .clk         (clk),
        .rst_n       (reset),
        .clear_i     (fill_start),
        .wr_en_i     (in_fill & ack),
        .wdata_i     (mem_rdata),
        .beat_o      (beat),
        .last_beat_o (last_beat),
        .line_o      (fill_line)
    );

    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign fill_prog_valid = fill_prog_valid_q;
    assign fill_data_valid = fill_data_valid_q;
    assign fill_addr       = line_addr_q[FILL_AW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= ST_IDLE;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            fill_prog_valid_q <= 1'b0;
            fill_data_valid_q <= 1'b0;
            line_addr_q       <= '0;
        end else begin
            fill_prog_valid_q <= 1'b0;
            fill_data_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!wb_empty) begin
                        state_q     <= ST_WB;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wb_addr[MEM_AW+1:2];
                        mem_wdata_q <= wb_data;
                    end else if (fill_start) begin
                        state_q     <= elig_data ? ST_FILL_D : ST_FILL_P;
                        line_addr_q <= start_addr;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= {start_addr, {BEAT_W{1'b0}}};
                    end
                end
                ST_WB: begin
                    if (ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                ST_FILL_D, ST_FILL_P: begin
                    if (ack) begin
                        if (last_beat) begin
                            mem_req_q <= 1'b0;
                            if (state_q == ST_FILL_D) begin
                                state_q           <= ST_DONE_D;
                                fill_data_valid_q <= 1'b1;
                            end else begin
                                state_q           <= ST_DONE_P;
                                fill_prog_valid_q <= 1'b1;
                            end
                        end else begin
                            mem_addr_q <= {line_addr_q, beat + BEAT_W'(1)};
                        end
                    end
                end
                ST_DONE_D, ST_DONE_P: state_q <= ST_IDLE;
                default:              state_q <= ST_IDLE;
            endcase
        end
    end

    // A low request always forgets the served line, even in the DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            served_data_q      <= 1'b0;
            served_addr_data_q <= '0;
            served_prog_q      <= 1'b0;
            served_addr_prog_q <= '0;
        end else begin
            if (!is_req_data) begin
                served_data_q <= 1'b0;
            end else if (state_q == ST_DONE_D) begin
                served_data_q      <= 1'b1;
                served_addr_data_q <= line_addr_q;
            end
            if (!is_req_prog) begin
                served_prog_q <= 1'b0;
            end else if (state_q == ST_DONE_P) begin
                served_prog_q      <= 1'b1;
                served_addr_prog_q <= line_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: expected accesses and fills queued by stimulus, popped by a monitor.
module tb_main_mem_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         is_req_prog;
    logic [17:0]  req_addr_prog;
    logic         is_req_data;
    logic [17:0]  req_addr_data;
    logic         wb_empty;
    logic [31:0]  wb_addr;
    logic [31:0]  wb_data;
    logic         wb_pop;
    logic         mem_req;
    logic         mem_we;
    logic [21:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         fill_prog_valid;
    logic         fill_data_valid;
    logic [511:0] fill_line;
    logic [7:0]   fill_addr;

    main_mem_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .is_req_prog     (is_req_prog),
        .req_addr_prog   (req_addr_prog),
        .is_req_data     (is_req_data),
        .req_addr_data   (req_addr_data),
        .wb_empty        (wb_empty),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .wb_pop          (wb_pop),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .fill_prog_valid (fill_prog_valid),
        .fill_data_valid (fill_data_valid),
        .fill_line       (fill_line),
        .fill_addr       (fill_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic         is_prog;
        logic [7:0]   addr;
        logic [511:0] line;
    } fill_t;

    acc_t        exp_acc[$];
    fill_t       exp_fill[$];
    logic [63:0] wb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_seen = 0;
    int          ack_gap = 0;
    int          rdata_mode = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void drive_wb();
        wb_empty = (wb_q.size() == 0);
        if (wb_empty) {wb_addr, wb_data} = 64'h0;
        else          {wb_addr, wb_data} = wb_q[0];
    endfunction

    // Memory model: gap 0 acks every 2nd cycle; rdata is the beat index (mode 0) or word address (mode 1).
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset && mem_req && !mem_ack) begin
                if (wait_cnt >= ack_gap) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (rdata_mode == 0) ? 32'(mem_addr[3:0]) : 32'(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        bit p;
        forever begin
            @(negedge clk);
            p = wb_pop;
            @(posedge clk);
            #1;
            if (p && wb_q.size() > 0) void'(wb_q.pop_front());
            drive_wb();
        end
    end

    // Monitor
    initial begin
        acc_t  ea;
        fill_t ef;
        forever begin
            @(negedge clk);
            if (reset && mem_req && mem_ack) begin
                acc_seen++;
                if (exp_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got we=%0b addr=%0h, expected none", mem_we, mem_addr);
                end else begin
                    ea = exp_acc.pop_front();
                    check("mem_we", mem_we, ea.we);
                    check("mem_addr", mem_addr, ea.addr);
                    if (ea.we) begin
                        check("mem_wdata", mem_wdata, ea.wdata);
                        check("wb_pop_on_write", wb_pop, 1'b1);
                    end else begin
                        check("wb_pop_on_read", wb_pop, 1'b0);
                    end
                end
            end
            if (fill_prog_valid || fill_data_valid) begin
                check("fill_onehot", fill_prog_valid & fill_data_valid, 1'b0);
                if (exp_fill.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fill: got prog=%0b data=%0b addr=%0h, expected none",
                             fill_prog_valid, fill_data_valid, fill_addr);
                end else begin
                    ef = exp_fill.pop_front();
                    check("fill_prog_valid", fill_prog_valid, ef.is_prog);
                    check("fill_data_valid", fill_data_valid, !ef.is_prog);
                    check("fill_addr", fill_addr, ef.addr);
                    check("fill_line", fill_line, ef.line);
                end
            end
        end
    end

    // A line fill reads word address {line, beat} for beats 0..15.
    task automatic push_fill(input bit is_prog, input logic [17:0] a, input int mode);
        acc_t  ea;
        fill_t ef;
        ef.is_prog = is_prog;
        ef.addr    = a[7:0];
        ef.line    = '0;
        for (int i = 0; i < 16; i++) begin
            ea.we    = 1'b0;
            ea.addr  = {a, 4'(i)};
            ea.wdata = '0;
            exp_acc.push_back(ea);
            ef.line[32*i +: 32] = (mode == 0) ? 32'(i) : {10'b0, a, 4'(i)};
        end
        exp_fill.push_back(ef);
    endtask

    task automatic wb_enqueue(input logic [31:0] baddr, input logic [31:0] data, input logic [21:0] waddr);
        acc_t ea;
        ea.we    = 1'b1;
        ea.addr  = waddr;
        ea.wdata = data;
        exp_acc.push_back(ea);
        wb_q.push_back({baddr, data});
        drive_wb();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_acc.size() != 0 || exp_fill.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_acc.size() != 0 || exp_fill.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d accesses and %0d fills pending, expected 0",
                     name, exp_acc.size(), exp_fill.size());
            exp_acc.delete();
            exp_fill.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (acc_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (acc_seen < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d acks, expected %0d", name, acc_seen, target);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 22'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_wb_pop"}, wb_pop, 1'b0);
        check({tag, "_fill_prog_valid"}, fill_prog_valid, 1'b0);
        check({tag, "_fill_data_valid"}, fill_data_valid, 1'b0);
        check({tag, "_fill_line"}, fill_line, 512'h0);
        check({tag, "_fill_addr"}, fill_addr, 8'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset         = 1'b0;
        is_req_prog   = 1'b0;
        req_addr_prog = '0;
        is_req_data   = 1'b0;
        req_addr_data = '0;
        drive_wb();
        step(3);
        check_idle_outputs("reset");
        reset = 1'b1;
        step(2);

        // T2: prog fill, ack every 2nd cycle, rdata = beat index
        ack_gap    = 0;
        rdata_mode = 0;
        push_fill(1'b1, 18'h0_12AB, 0);
        is_req_prog   = 1'b1;
        req_addr_prog = 18'h0_12AB;
        wait_drain("t2_prog_fill", 200);
        step(10);
        is_req_prog = 1'b0;
        step(3);

        // T3: two write-backs then data fill then prog fill
        ack_gap    = 1;
        rdata_mode = 1;
        wb_enqueue(32'h0000_1004, 32'hDEAD_0001, 22'h00_0401);
        wb_enqueue(32'h00AB_CDE8, 32'hDEAD_0002, 22'h2A_F37A);
        push_fill(1'b0, 18'h2_0040, 1);
        push_fill(1'b1, 18'h1_0001, 1);
        is_req_data   = 1'b1;
        req_addr_data = 18'h2_0040;
        is_req_prog   = 1'b1;
        req_addr_prog = 18'h1_0001;
        wait_drain("t3_priority", 800);

        // T4: held request is not refilled; a one-cycle drop re-arms it
        step(40);
        is_req_data = 1'b0;
        step(1);
        push_fill(1'b0, 18'h2_0040, 1);
        is_req_data = 1'b1;
        wait_drain("t4_dedupe", 400);
        step(5);
        is_req_data = 1'b0;
        is_req_prog = 1'b0;
        step(3);

        // T5: write-back arriving mid-fill waits for the whole line
        ack_gap = 0;
        push_fill(1'b1, 18'h3_1234, 1);
        base          = acc_seen;
        is_req_prog   = 1'b1;
        req_addr_prog = 18'h3_1234;
        wait_acks("t5_beat3", base + 3, 100);
        step(1);
        wb_enqueue(32'h0012_3458, 32'hCAFE_F00D, 22'h04_8D16);
        wait_drain("t5_wb_interleave", 300);
        step(5);
        is_req_prog = 1'b0;
        step(3);

        // T6: withdrawn request still completes with one push
        ack_gap = 1;
        push_fill(1'b1, 18'h0_0F0F, 1);
        base          = acc_seen;
        is_req_prog   = 1'b1;
        req_addr_prog = 18'h0_0F0F;
        wait_acks("t6_beat8", base + 8, 200);
        step(1);
        is_req_prog = 1'b0;
        wait_drain("t6_withdraw", 300);
        step(20);

        // T1: reset in the middle of a data fill
        push_fill(1'b0, 18'h0_5555, 1);
        base          = acc_seen;
        is_req_data   = 1'b1;
        req_addr_data = 18'h0_5555;
        wait_acks("t1_beat5", base + 5, 200);
        #2;
        reset = 1'b0;
        #1;
        check("t1_reset_drops_req", mem_req, 1'b0);
        exp_acc.delete();
        exp_fill.delete();
        is_req_data = 1'b0;
        step(2);
        reset = 1'b1;
        step(3);
        check_idle_outputs("t1_after_reset");

        push_fill(1'b0, 18'h0_5555, 1);
        is_req_data = 1'b1;
        wait_drain("t1_refill", 300);
        is_req_data = 1'b0;
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
